keypad_code_lock: RTL and testbench

KEYPAD_CODE_LOCK -- requirements
Module: keypad_code_lock

---
 rtl/keypad_code_lock.sv | 185 ++++++++++++++++++
 tb/tb_keypad_code_lock.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_code_lock.sv
// keypad_code_lock: four-digit keypad code lock with timed unlock window.
// Optional lockout after repeated failures: define KEYPAD_CODE_LOCK_LOCKOUT_EN.
// Without the macro, FAIL always returns to ENTRY and alarm is tied low.
module keypad_code_lock #(
    parameter logic [15:0] CODE           = 16'h1234,
    parameter int unsigned UNLOCK_CYCLES  = 1000,
    parameter int unsigned LOCKOUT_CYCLES = 5000,
    parameter int unsigned MAX_FAIL       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key,
    input  logic       key_valid,
    output logic       unlocked,
    output logic       err,
    output logic       alarm,
    output logic [2:0] digit_count
);

    localparam logic [15:0] UNLOCK_LOAD  = 16'(UNLOCK_CYCLES);
    localparam logic [15:0] LOCKOUT_LOAD = 16'(LOCKOUT_CYCLES);
    localparam logic [2:0]  FAIL_LIMIT   = 3'(MAX_FAIL);
    localparam logic [2:0]  DIGITS_MAX   = 3'd4;
    localparam logic [3:0]  KEY_STAR     = 4'hE;
    localparam logic [3:0]  KEY_HASH     = 4'hF;

    typedef enum logic [2:0] {
        ST_ENTRY,
        ST_CHECK,
        ST_OPEN,
        ST_FAIL,
        ST_LOCKOUT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] code_buf;
    logic [15:0] code_buf_next;
    logic [2:0]  count;
    logic [2:0]  count_next;
    logic        overflow;
    logic        overflow_next;
    logic [2:0]  fail_cnt;
    logic [2:0]  fail_next;
    logic [15:0] timer;
    logic [15:0] timer_next;
    logic        kv_q;

    logic        press;
    logic        key_is_digit;
    logic        match;
    logic [2:0]  fail_inc;

    // Rising edge of key_valid is the single press event
    assign press        = key_valid & ~kv_q;
    assign key_is_digit = (key <= 4'd9);
    assign match        = (count == DIGITS_MAX) & ~overflow & (code_buf == CODE);
    assign fail_inc     = (fail_cnt >= FAIL_LIMIT) ? FAIL_LIMIT : fail_cnt + 3'd1;
    assign digit_count  = count;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_ENTRY;
            code_buf <= 16'd0;
            count    <= 3'd0;
            overflow <= 1'b0;
            fail_cnt <= 3'd0;
            timer    <= 16'd0;
            kv_q     <= 1'b0;
        end else begin
            state    <= state_next;
            code_buf <= code_buf_next;
            count    <= count_next;
            overflow <= overflow_next;
            fail_cnt <= fail_next;
            timer    <= timer_next;
            kv_q     <= key_valid;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_next    = state;
        code_buf_next = code_buf;
        count_next    = count;
        overflow_next = overflow;
        fail_next     = fail_cnt;
        timer_next    = timer;

        case (state)
            ST_ENTRY: begin
                if (press) begin
                    if (key_is_digit) begin
                        if (count < DIGITS_MAX) begin
                            code_buf_next = {code_buf[11:0], key};
                            count_next    = count + 3'd1;
                        end else begin
                            overflow_next = 1'b1;
                        end
                    end else if (key == KEY_STAR) begin
                        code_buf_next = 16'd0;
                        count_next    = 3'd0;
                        overflow_next = 1'b0;
                    end else if (key == KEY_HASH) begin
                        state_next = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                code_buf_next = 16'd0;
                count_next    = 3'd0;
                overflow_next = 1'b0;
                if (match) begin
                    state_next = ST_OPEN;
                    fail_next  = 3'd0;
                end else begin
                    state_next = ST_FAIL;
                end
            end
            ST_OPEN: begin
                if (press && key == KEY_HASH) begin
                    state_next = ST_ENTRY;
                end else if (timer <= 16'd1) begin
                    state_next = ST_ENTRY;
                end else begin
                    timer_next = timer - 16'd1;
                end
            end
            ST_FAIL: begin
                fail_next = fail_inc;
`ifdef KEYPAD_CODE_LOCK_LOCKOUT_EN
                state_next = (fail_inc >= FAIL_LIMIT) ? ST_LOCKOUT : ST_ENTRY;
`else
                state_next = ST_ENTRY;
`endif
            end
            ST_LOCKOUT: begin
                if (timer <= 16'd1) begin
                    state_next = ST_ENTRY;
                    fail_next  = 3'd0;
                end else begin
                    timer_next = timer - 16'd1;
                end
            end
            default: begin
                state_next = ST_ENTRY;
            end
        endcase

        // Shared timer is loaded on entry to either timed state
        if (state_next != state) begin
            if (state_next == ST_OPEN) begin
                timer_next = UNLOCK_LOAD;
            end else if (state_next == ST_LOCKOUT) begin
                timer_next = LOCKOUT_LOAD;
            end
        end
    end

    // Registered status outputs, aligned with the state they report
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            unlocked <= 1'b0;
            err      <= 1'b0;
        end else begin
            unlocked <= (state_next == ST_OPEN);
            err      <= (state_next == ST_FAIL);
        end
    end

`ifdef KEYPAD_CODE_LOCK_LOCKOUT_EN
    // Alarm follows the lockout state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm <= 1'b0;
        end else begin
            alarm <= (state_next == ST_LOCKOUT);
        end
    end
`else
    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_code_lock.sv
// Directed testbench for keypad_code_lock (UNLOCK=8, LOCKOUT=12, MAX_FAIL=3).
module tb_keypad_code_lock;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key;
    logic       key_valid;
    logic       unlocked;
    logic       err;
    logic       alarm;
    logic [2:0] digit_count;

    int vectors = 0;
    int miscompares = 0;

    keypad_code_lock #(
        .CODE           (16'h1234),
        .UNLOCK_CYCLES  (8),
        .LOCKOUT_CYCLES (12),
        .MAX_FAIL       (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key         (key),
        .key_valid   (key_valid),
        .unlocked    (unlocked),
        .err         (err),
        .alarm       (alarm),
        .digit_count (digit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One key press: held for one edge, released for one edge
    task automatic press(input logic [3:0] k);
        key       = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic enter4(input logic [15:0] code);
        press(code[15:12]);
        press(code[11:8]);
        press(code[7:4]);
        press(code[3:0]);
    endtask

    // Count consecutive unlocked samples, bounded
    task automatic count_open(output int n, output int errs);
        n    = 0;
        errs = 0;
        while (unlocked === 1'b1 && n < 200) begin
            n++;
            if (err === 1'b1) errs++;
            @(negedge clk);
        end
    endtask

    task automatic wrong_code(input string tag);
        enter4(16'h9999);
        press(4'hF);
        chk({tag, "_err"}, int'(err), 1);
        chk({tag, "_unl"}, int'(unlocked), 0);
        @(negedge clk);
        chk({tag, "_err_end"}, int'(err), 0);
    endtask

    int n;
    int errs;

    initial begin
        reset     = 1'b1;
        key       = 4'h0;
        key_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_unlocked", int'(unlocked), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_alarm", int'(alarm), 0);
        chk("rst_dc", int'(digit_count), 0);
        reset = 1'b0;

        // Correct code; first press right after reset release
        press(4'h1);
        chk("ok_dc1", int'(digit_count), 1);
        press(4'h2);
        chk("ok_dc2", int'(digit_count), 2);
        press(4'h3);
        chk("ok_dc3", int'(digit_count), 3);
        press(4'h4);
        chk("ok_dc4", int'(digit_count), 4);
        press(4'hF);
        chk("ok_open_dc", int'(digit_count), 0);
        count_open(n, errs);
        chk("ok_open_len", n, 8);
        chk("ok_open_err", errs, 0);
        chk("ok_after_dc", int'(digit_count), 0);

        // Wrong last digit
        enter4(16'h1235);
        press(4'hF);
        chk("bad_err", int'(err), 1);
        chk("bad_unl", int'(unlocked), 0);
        chk("bad_dc", int'(digit_count), 0);
        @(negedge clk);
        chk("bad_err_end", int'(err), 0);

        // Fifth digit overflows, attempt fails
        enter4(16'h1234);
        press(4'h5);
        chk("ovf_dc", int'(digit_count), 4);
        press(4'hF);
        chk("ovf_err", int'(err), 1);
        chk("ovf_unl", int'(unlocked), 0);
        @(negedge clk);

        // Star clears partial entry, then correct code opens
        press(4'h1);
        press(4'h2);
        press(4'hE);
        chk("star_dc", int'(digit_count), 0);
        enter4(16'h1234);
        press(4'hF);
        chk("star_open", int'(unlocked), 1);
        chk("star_err", int'(err), 0);
        count_open(n, errs);
        chk("star_open_len", n, 8);
        chk("star_open_err", errs, 0);

        // Early relock with '#'
        enter4(16'h1234);
        press(4'hF);
        chk("relock_open", int'(unlocked), 1);
        press(4'hF);
        chk("relock_unl", int'(unlocked), 0);
        chk("relock_dc", int'(digit_count), 0);

        // Letters are ignored
        press(4'hA);
        chk("letter_dc0", int'(digit_count), 0);
        press(4'h7);
        press(4'hC);
        chk("letter_dc1", int'(digit_count), 1);
        press(4'hE);

        // Long hold yields one digit
        key       = 4'h4;
        key_valid = 1'b1;
        repeat (20) @(negedge clk);
        key_valid = 1'b0;
        @(negedge clk);
        chk("hold_dc", int'(digit_count), 1);
        press(4'hE);
        chk("hold_clr", int'(digit_count), 0);

        // Three consecutive failures
        wrong_code("f1");
        wrong_code("f2");
        enter4(16'h9999);
        press(4'hF);
        chk("f3_err", int'(err), 1);
        chk("f3_alarm_pre", int'(alarm), 0);
        @(negedge clk);
`ifdef KEYPAD_CODE_LOCK_LOCKOUT_EN
        chk("lock_alarm_first", int'(alarm), 1);
        enter4(16'h1234);
        press(4'hF);
        chk("lock_alarm_mid", int'(alarm), 1);
        chk("lock_ign_unl", int'(unlocked), 0);
        chk("lock_ign_dc", int'(digit_count), 0);
        @(negedge clk);
        chk("lock_alarm_last", int'(alarm), 1);
        @(negedge clk);
        chk("lock_alarm_end", int'(alarm), 0);
`else
        chk("nolock_alarm", int'(alarm), 0);
        chk("nolock_err_end", int'(err), 0);
`endif
        enter4(16'h1234);
        press(4'hF);
        chk("post_fail_open", int'(unlocked), 1);
        chk("post_fail_alarm", int'(alarm), 0);
        count_open(n, errs);
        chk("post_fail_len", n, 8);

        // Asynchronous reset during OPEN
        enter4(16'h1234);
        press(4'hF);
        chk("rst_open_pre", int'(unlocked), 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_open_unl", int'(unlocked), 0);
        chk("rst_open_dc", int'(digit_count), 0);
        @(negedge clk);
        reset = 1'b0;
        press(4'h4);
        chk("rst_after_dc", int'(digit_count), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
